// File: rtl/scope_pkg.sv
// Shared definitions for the scope capture slice: FSM states, default widths
// and trigger-polarity constants.
package scope_pkg;

    localparam int unsigned DATA_W_DEF = 12;
    localparam int unsigned ADDR_W_DEF = 8;

    localparam logic POL_FALLING = 1'b0;
    localparam logic POL_RISING  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREFILL,
        ST_WAIT_TRIG,
        ST_POST,
        ST_DONE
    } state_t;

endpackage

// File: rtl/scope_ram.sv
// Capture buffer: simple dual-port RAM, one write port, one registered read port.
// The array carries no reset so it maps onto block RAM.
module scope_ram #(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/scope_capture.sv
// Pre/post-trigger sample capture into a circular buffer with edge or forced
// trigger and trigger-relative readout.
module scope_capture
    import scope_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned PRE_TRIG = 64
) (
    input  logic              CLOCK_50,
    input  logic              RESET,
    input  logic [DATA_W-1:0] SAMPLE,
    input  logic              SAMPLE_VALID,
    input  logic [DATA_W-1:0] TRIG_LEVEL,
    input  logic              TRIG_RISING,
    input  logic              ARM,
    input  logic              FORCE,
    input  logic [ADDR_W-1:0] RD_ADDR,
    output logic [DATA_W-1:0] RD_DATA,
    output logic              BUSY,
    output logic              DONE,
    output logic [ADDR_W-1:0] TRIG_PTR
);

    localparam int unsigned       DEPTH      = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] PRE_TRIG_A = ADDR_W'(PRE_TRIG);
    localparam logic [ADDR_W-1:0] POST_LEN   = ADDR_W'(DEPTH - PRE_TRIG - 1);

    state_t            state, state_n;
    logic [ADDR_W-1:0] wr_ptr, wr_ptr_n;
    logic [ADDR_W-1:0] cnt, cnt_n;
    logic [ADDR_W-1:0] trig_ptr, trig_ptr_n;
    logic [DATA_W-1:0] prev_sample, prev_sample_n;
    logic              prev_valid, prev_valid_n;
    logic              force_lat, force_lat_n;
    logic              we;
    logic              edge_hit;
    logic              rd_en_q;
    logic [ADDR_W-1:0] rd_phys;
    logic [DATA_W-1:0] ram_q;

    always_comb begin
        if (TRIG_RISING == POL_RISING) begin
            edge_hit = prev_valid && (prev_sample < TRIG_LEVEL) && (SAMPLE >= TRIG_LEVEL);
        end else begin
            edge_hit = prev_valid && (prev_sample > TRIG_LEVEL) && (SAMPLE <= TRIG_LEVEL);
        end
    end

    always_comb begin
        state_n       = state;
        wr_ptr_n      = wr_ptr;
        cnt_n         = cnt;
        trig_ptr_n    = trig_ptr;
        prev_sample_n = prev_sample;
        prev_valid_n  = prev_valid;
        force_lat_n   = force_lat;
        we            = 1'b0;

        if (ARM) begin
            // ARM overrides everything, including a coincident sample
            state_n      = ST_PREFILL;
            wr_ptr_n     = '0;
            cnt_n        = '0;
            prev_valid_n = 1'b0;
            force_lat_n  = 1'b0;
        end else begin
            if (SAMPLE_VALID && (state == ST_PREFILL || state == ST_WAIT_TRIG || state == ST_POST)) begin
                we            = 1'b1;
                wr_ptr_n      = wr_ptr + 1'b1;
                prev_sample_n = SAMPLE;
                prev_valid_n  = 1'b1;
            end
            case (state)
                ST_PREFILL: begin
                    if (SAMPLE_VALID) begin
                        if (cnt == PRE_TRIG_A - 1'b1) begin
                            state_n = ST_WAIT_TRIG;
                            cnt_n   = '0;
                        end else begin
                            cnt_n = cnt + 1'b1;
                        end
                    end
                end
                ST_WAIT_TRIG: begin
                    if (FORCE) begin
                        force_lat_n = 1'b1;
                    end
                    if (SAMPLE_VALID && (force_lat || edge_hit)) begin
                        trig_ptr_n  = wr_ptr;
                        force_lat_n = 1'b0;
                        cnt_n       = POST_LEN;
                        state_n     = (POST_LEN == '0) ? ST_DONE : ST_POST;
                    end
                end
                ST_POST: begin
                    if (SAMPLE_VALID) begin
                        cnt_n = cnt - 1'b1;
                        if (cnt == ADDR_W'(1)) begin
                            state_n = ST_DONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state       <= ST_IDLE;
            wr_ptr      <= '0;
            cnt         <= '0;
            trig_ptr    <= '0;
            prev_sample <= '0;
            prev_valid  <= 1'b0;
            force_lat   <= 1'b0;
            rd_en_q     <= 1'b0;
        end else begin
            state       <= state_n;
            wr_ptr      <= wr_ptr_n;
            cnt         <= cnt_n;
            trig_ptr    <= trig_ptr_n;
            prev_sample <= prev_sample_n;
            prev_valid  <= prev_valid_n;
            force_lat   <= force_lat_n;
            rd_en_q     <= (state == ST_DONE);
        end
    end

    assign rd_phys = trig_ptr - PRE_TRIG_A + RD_ADDR;

    scope_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (CLOCK_50),
        .we    (we),
        .waddr (wr_ptr),
        .wdata (SAMPLE),
        .raddr (rd_phys),
        .rdata (ram_q)
    );

    // Only a completed capture has a fully written buffer; mask reads otherwise
    // so unwritten RAM locations never reach the output.
    assign RD_DATA  = rd_en_q ? ram_q : '0;
    assign BUSY     = (state == ST_PREFILL) || (state == ST_WAIT_TRIG) || (state == ST_POST);
    assign DONE     = (state == ST_DONE);
    assign TRIG_PTR = trig_ptr;

endmodule

// File: tb/tb_scope_capture.sv
// Randomised self-checking bench for scope_capture against a sample-history model.
module tb_scope_capture;

    localparam int DATA_W   = 12;
    localparam int ADDR_W   = 8;
    localparam int DEPTH    = 256;
    localparam int PRE_TRIG = 64;

    logic              CLOCK_50 = 1'b0;
    logic              RESET = 1'b1;
    logic [DATA_W-1:0] SAMPLE = '0;
    logic              SAMPLE_VALID = 1'b0;
    logic [DATA_W-1:0] TRIG_LEVEL = '0;
    logic              TRIG_RISING = 1'b1;
    logic              ARM = 1'b0;
    logic              FORCE = 1'b0;
    logic [ADDR_W-1:0] RD_ADDR = '0;
    logic [DATA_W-1:0] RD_DATA;
    logic              BUSY;
    logic              DONE;
    logic [ADDR_W-1:0] TRIG_PTR;

    int n_checks = 0;
    int n_pass   = 0;

    // model: every sample accepted since ARM, index of trigger sample
    int q[$];
    int m_trig;
    int m_level;
    bit m_rising;
    bit m_force_pend;
    int sq_phase;

    scope_capture #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .PRE_TRIG (PRE_TRIG)
    ) dut (
        .CLOCK_50     (CLOCK_50),
        .RESET        (RESET),
        .SAMPLE       (SAMPLE),
        .SAMPLE_VALID (SAMPLE_VALID),
        .TRIG_LEVEL   (TRIG_LEVEL),
        .TRIG_RISING  (TRIG_RISING),
        .ARM          (ARM),
        .FORCE        (FORCE),
        .RD_ADDR      (RD_ADDR),
        .RD_DATA      (RD_DATA),
        .BUSY         (BUSY),
        .DONE         (DONE),
        .TRIG_PTR     (TRIG_PTR)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    function automatic int gen_sample(input int mode, input int i);
        case (mode)
            0:       return (16 * i) % 4096;
            1:       return (((i + sq_phase) / 3) % 2) ? 4095 : 0;
            2:       return 100;
            3:       return int'($urandom_range(0, 4095));
            default: return i % 4096;
        endcase
    endfunction

    function automatic void model_push(input int v);
        int i;
        bit fire;
        i = q.size();
        if (m_trig < 0 && i >= PRE_TRIG) begin
            if (m_rising) fire = (q[i-1] < m_level) && (v >= m_level);
            else          fire = (q[i-1] > m_level) && (v <= m_level);
            if (m_force_pend || fire) begin
                m_trig       = i;
                m_force_pend = 1'b0;
            end
        end
        q.push_back(v);
    endfunction

    function automatic bit model_done();
        return (m_trig >= 0) && (q.size() == m_trig + DEPTH - PRE_TRIG);
    endfunction

    task automatic feed(input int v, input int gap);
        @(negedge CLOCK_50);
        SAMPLE       = DATA_W'(v);
        SAMPLE_VALID = 1'b1;
        @(negedge CLOCK_50);
        SAMPLE_VALID = 1'b0;
        repeat (gap - 2) @(negedge CLOCK_50);
    endtask

    task automatic do_arm(input bit with_sample);
        @(negedge CLOCK_50);
        ARM = 1'b1;
        if (with_sample) begin
            SAMPLE       = DATA_W'(3333);
            SAMPLE_VALID = 1'b1;
        end
        @(negedge CLOCK_50);
        ARM          = 1'b0;
        SAMPLE_VALID = 1'b0;
        q.delete();
        m_trig       = -1;
        m_force_pend = 1'b0;
    endtask

    // Feeds samples until the model says the capture is complete (or stop_post
    // samples past the trigger), pulsing FORCE once force_at samples are in.
    task automatic run_capture(input int mode, input int level, input bit rising,
                               input int force_at, input int gap, input bit arm_coinc,
                               input int stop_post);
        int v;
        m_level     = level;
        m_rising    = rising;
        TRIG_LEVEL  = DATA_W'(level);
        TRIG_RISING = rising;
        do_arm(arm_coinc);
        while (!model_done() && q.size() < 5000) begin
            if (stop_post >= 0 && m_trig >= 0 && q.size() == m_trig + 1 + stop_post) break;
            if (q.size() == force_at) begin
                @(negedge CLOCK_50);
                FORCE = 1'b1;
                @(negedge CLOCK_50);
                FORCE = 1'b0;
                if (q.size() >= PRE_TRIG && m_trig < 0) m_force_pend = 1'b1;
            end
            v = gen_sample(mode, q.size());
            feed(v, gap);
            model_push(v);
        end
        n_checks++;
        if (q.size() >= 5000) $display("FAIL capture_budget: samples=%0d trig=%0d", q.size(), m_trig);
        else n_pass++;
    endtask

    task automatic check_done(input string name);
        n_checks++;
        if (DONE !== 1'b1 || BUSY !== 1'b0)
            $display("FAIL %s_done: DONE=%b BUSY=%b expected DONE=1 BUSY=0", name, DONE, BUSY);
        else n_pass++;
        n_checks++;
        if (TRIG_PTR !== ADDR_W'(m_trig))
            $display("FAIL %s_trig_ptr: got %0d expected %0d", name, TRIG_PTR, m_trig % DEPTH);
        else n_pass++;
    endtask

    task automatic read_at(input int a, output int d);
        @(negedge CLOCK_50);
        RD_ADDR = ADDR_W'(a);
        @(posedge CLOCK_50);
        #1;
        d = int'(RD_DATA);
    endtask

    task automatic check_readout(input string name);
        int d, exp_v;
        for (int k = 0; k < DEPTH; k++) begin
            read_at(k, d);
            exp_v = q[m_trig - PRE_TRIG + k];
            n_checks++;
            if (d !== exp_v) $display("FAIL %s_rd[%0d]: got %0d expected %0d", name, k, d, exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (3) @(posedge CLOCK_50);
        #1;
        n_checks++;
        if (BUSY !== 1'b0 || DONE !== 1'b0 || TRIG_PTR !== '0 || RD_DATA !== '0)
            $display("FAIL reset: BUSY=%b DONE=%b TRIG_PTR=%0d RD_DATA=%0d expected all 0",
                     BUSY, DONE, TRIG_PTR, RD_DATA);
        else n_pass++;
        @(negedge CLOCK_50);
        RESET = 1'b0;
        feed(555, 2);
        n_checks++;
        if (BUSY !== 1'b0 || DONE !== 1'b0)
            $display("FAIL idle_ignores: BUSY=%b DONE=%b expected 0 0", BUSY, DONE);
        else n_pass++;
    endtask

    task automatic test_ramp_rising();
        int d;
        run_capture(0, 1500, 1'b1, -1, 4, 1'b0, -1);
        check_done("ramp");
        n_checks++;
        if (TRIG_PTR !== 8'd94) $display("FAIL ramp_trig_idx: got %0d expected 94", TRIG_PTR);
        else n_pass++;
        read_at(PRE_TRIG, d);
        n_checks++;
        if (d !== 1504) $display("FAIL ramp_trig_sample: got %0d expected 1504", d);
        else n_pass++;
        read_at(0, d);
        n_checks++;
        if (d !== 1504 - 64 * 16) $display("FAIL ramp_oldest: got %0d expected %0d", d, 1504 - 64 * 16);
        else n_pass++;
        check_readout("ramp");
    endtask

    task automatic test_falling_square();
        sq_phase = int'($urandom_range(0, 5));
        run_capture(1, 2048, 1'b0, -1, 2, 1'b0, -1);
        check_done("square");
        n_checks++;
        if (q[m_trig] != 0 || q[m_trig-1] != 4095)
            $display("FAIL square_model_edge: trig=%0d prev=%0d expected 0 after 4095", q[m_trig], q[m_trig-1]);
        else n_pass++;
        check_readout("square");
    endtask

    task automatic test_force();
        run_capture(2, 2048, 1'b1, PRE_TRIG + 5, 2, 1'b0, -1);
        check_done("force");
        n_checks++;
        if (TRIG_PTR !== ADDR_W'(PRE_TRIG + 5))
            $display("FAIL force_next_sample: got %0d expected %0d", TRIG_PTR, PRE_TRIG + 5);
        else n_pass++;
        check_readout("force");
    endtask

    task automatic test_arm_coincident();
        run_capture(2, 2048, 1'b1, PRE_TRIG, 2, 1'b1, -1);
        check_done("arm_coinc");
        n_checks++;
        if (TRIG_PTR !== ADDR_W'(PRE_TRIG))
            $display("FAIL arm_coinc_drop: got %0d expected %0d", TRIG_PTR, PRE_TRIG);
        else n_pass++;
    endtask

    task automatic test_reset_in_post();
        run_capture(2, 2048, 1'b1, PRE_TRIG + 2, 2, 1'b0, 10);
        n_checks++;
        if (BUSY !== 1'b1 || DONE !== 1'b0)
            $display("FAIL post_busy: BUSY=%b DONE=%b expected 1 0", BUSY, DONE);
        else n_pass++;
        @(negedge CLOCK_50);
        RESET = 1'b1;
        @(posedge CLOCK_50);
        #1;
        n_checks++;
        if (BUSY !== 1'b0 || DONE !== 1'b0 || TRIG_PTR !== '0)
            $display("FAIL reset_in_post: BUSY=%b DONE=%b TRIG_PTR=%0d expected 0 0 0", BUSY, DONE, TRIG_PTR);
        else n_pass++;
        @(negedge CLOCK_50);
        RESET = 1'b0;
    endtask

    task automatic test_wrap();
        run_capture(4, 4095, 1'b1, PRE_TRIG + 600, 2, 1'b0, -1);
        check_done("wrap");
        check_readout("wrap");
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            run_capture(3, int'($urandom_range(200, 3900)), 1'($urandom_range(0, 1)),
                        1500, 2, 1'b0, -1);
            check_done("random");
            check_readout("random");
        end
    endtask

    initial begin
        test_reset();
        test_ramp_rising();
        test_falling_square();
        test_force();
        test_arm_coincident();
        test_reset_in_post();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
